// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and default widths for the two-port BRAM arbiter.
package bram_port_arbiter_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/bram_port_arbiter_rr_grant2.sv
// Two-requester round-robin grant with optional burst lock
// (enabled by defining BRAM_ARB_BURST_LOCK_EN).
module rr_grant2
  import bram_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a_req,
  input  logic b_req,
`ifdef BRAM_ARB_BURST_LOCK_EN
  input  logic a_lock,
  input  logic b_lock,
`endif
  output logic a_gnt,
  output logic b_gnt
);

  port_e last_win;
  logic  pick_a;

`ifdef BRAM_ARB_BURST_LOCK_EN
  logic  lock_vld;
  port_e lock_own;

  always_comb begin
    pick_a = a_req;
    if (a_req && b_req)
      pick_a = lock_vld ? (lock_own == PORT_A) : (last_win == PORT_B);
  end

  // Owner's next grant carries its lock bit forward; a non-owner grant or an
  // idle cycle can only happen when the owner dropped req, so it ends the lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld <= 1'b0;
      lock_own <= PORT_A;
    end else begin
      lock_vld <= (a_gnt && a_lock) || (b_gnt && b_lock);
      if (a_gnt)      lock_own <= PORT_A;
      else if (b_gnt) lock_own <= PORT_B;
    end
  end
`else
  always_comb begin
    pick_a = a_req && (!b_req || (last_win == PORT_B));
  end
`endif

  assign a_gnt = !rst && pick_a;
  assign b_gnt = !rst && b_req && !pick_a;

  always_ff @(posedge clk) begin
    if (rst)        last_win <= PORT_B;
    else if (a_gnt) last_win <= PORT_A;
    else if (b_gnt) last_win <= PORT_B;
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM (1-cycle read latency) between an SPI side (A)
// and an engine side (B). Optional BRAM_ARB_BURST_LOCK_EN adds a_lock/b_lock.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
`ifdef BRAM_ARB_BURST_LOCK_EN
  input  logic              a_lock,
  input  logic              b_lock,
`endif
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_data_in,
  input  logic [DATA_W-1:0] bram_data_out,
  output logic              busy
);

  logic              gnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_pend;
  port_e             rd_port;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  rr_grant2 u_grant (
    .clk    (clk),
    .rst    (rst),
    .a_req  (a_req),
    .b_req  (b_req),
`ifdef BRAM_ARB_BURST_LOCK_EN
    .a_lock (a_lock),
    .b_lock (b_lock),
`endif
    .a_gnt  (a_gnt),
    .b_gnt  (b_gnt)
  );

  assign gnt = a_gnt || b_gnt;

  // BRAM side follows the winner combinationally and parks on the last access.
  always_comb begin
    bram_addr    = addr_q;
    bram_data_in = wdata_q;
    bram_we      = 1'b0;
    if (a_gnt) begin
      bram_addr    = a_addr;
      bram_data_in = a_wdata;
      bram_we      = a_we;
    end else if (b_gnt) begin
      bram_addr    = b_addr;
      bram_data_in = b_wdata;
      bram_we      = b_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (gnt) begin
      addr_q  <= bram_addr;
      wdata_q <= bram_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_port <= PORT_A;
    end else begin
      rd_pend <= gnt && !bram_we;
      rd_port <= b_gnt ? PORT_B : PORT_A;
    end
  end

  // Gating with rst drops a read that was in flight when reset arrived.
  assign a_rvalid = rd_pend && !rst && (rd_port == PORT_A);
  assign b_rvalid = rd_pend && !rst && (rd_port == PORT_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_rvalid) a_rdata_q <= bram_data_out;
      if (b_rvalid) b_rdata_q <= bram_data_out;
    end
  end

  assign a_rdata = a_rvalid ? bram_data_out : a_rdata_q;
  assign b_rdata = b_rvalid ? bram_data_out : b_rdata_q;
  assign busy    = gnt || (rd_pend && !rst);

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 15, BRAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, BRAM data width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is rising-edge clk.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have ports a_req, a_we  input  1 each  port A (SPI transfer side) access request and write-enable.
REQ-006 The block SHALL have ports a_addr  input  ADDR_W and a_wdata  input  DATA_W  port A address and write data.
REQ-007 The block SHALL have ports a_gnt, a_rvalid  output  1 each and a_rdata  output  DATA_W  port A grant, read-valid and read data.
REQ-008 The block SHALL have ports b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  with the same directions and widths  port B (processing engine side) equivalents of REQ-005..007.
REQ-009 The block SHALL have ports bram_addr  output  ADDR_W, bram_we  output  1, bram_data_in  output  DATA_W and bram_data_out  input  DATA_W  the single-port BRAM, 1-cycle read latency.
REQ-010 The block SHALL have port busy  output  1, high in any cycle a grant is issued or a read is pending.

Function
REQ-011 Arbitration SHALL be combinational per cycle: when a_req or b_req is high, exactly one of a_gnt/b_gnt SHALL be high in that cycle; when neither is high, both SHALL be low.
REQ-012 With both requests high, the winner SHALL be the port not recorded in register last_win (round-robin); after reset last_win = B, so A wins the first contention.
REQ-013 last_win SHALL update to the granted port on every cycle with a grant; otherwise it SHALL hold.
REQ-014 In a grant cycle, bram_addr/bram_we/bram_data_in SHALL equal the winner's addr/we/wdata; with no grant, bram_we SHALL be 0 and bram_addr/bram_data_in SHALL hold their last driven value.
REQ-015 A granted read (we=0) SHALL produce a one-cycle pulse on the winner's rvalid exactly one cycle after the grant, with rdata = bram_data_out in that cycle.
REQ-016 A granted write SHALL complete in the grant cycle; no rvalid SHALL be produced.
REQ-017 a_rdata/b_rdata SHALL hold their last valid value when rvalid is low.
REQ-018 Back-to-back grants SHALL be supported every cycle; read pipelining SHALL allow a new grant in the same cycle as a previous rvalid.
REQ-019 A requester whose req stays high while not granted SHALL be granted within 2 cycles (no starvation).
REQ-020 A losing requester SHALL keep req and its addr/we/wdata stable until granted; the block does not buffer them.

Reset
REQ-021 While rst is high at a clk edge: last_win=B, all gnt/rvalid=0, rdata=0, bram_we=0, bram_addr=0, bram_data_in=0, busy=0, lock cleared.
REQ-022 A read granted in the cycle before rst SHALL NOT produce rvalid after reset.

Configuration
REQ-023 Macro BRAM_ARB_BURST_LOCK_EN SHALL add inputs a_lock and b_lock (1 bit each).
REQ-024 When BRAM_ARB_BURST_LOCK_EN is defined, a grant with lock=1 SHALL make that port the lock owner. The owner SHALL win every contention until a grant with lock=0, or until its req drops for one cycle.
REQ-025 When BRAM_ARB_BURST_LOCK_EN is not defined, the lock ports and lock logic SHALL be absent and arbitration SHALL be pure round-robin.

Structure
REQ-026 A shared package SHALL hold the port-ID enum (PORT_A, PORT_B) and the ADDR_W/DATA_W defaults.
REQ-027 The arbitration decision (reqs, last_win, lock) SHALL be a sub-module rr_grant2. The BRAM mux and read-return pipeline SHALL remain in the top module.

Verification
REQ-028 a_req only, read addr 0x0010 with BRAM[0x0010]=0x5A -> a_gnt same cycle, a_rvalid next cycle, a_rdata=0x5A, b_gnt never high.
REQ-029 a_req and b_req both held high for 4 cycles, both reads -> grant sequence A,B,A,B; each rvalid one cycle after its grant.
REQ-030 b write 0x3C to 0x7FFF, then a read 0x7FFF next cycle -> a_rdata=0x3C; bram_we high only in the write grant cycle.
REQ-031 rst asserted the cycle after an a read grant -> no a_rvalid; the first contention after reset grants A.
REQ-032 With BRAM_ARB_BURST_LOCK_EN: b_lock=1 for 3 grants while a_req is held -> B,B,B, then b_lock=0 -> next contention grants A.
